// File: rtl/avst_word2byte_pkg.sv
// avst_word2byte_pkg: shared state type, default word width and last-byte index helper
// for the word-to-byte serializer.
package avst_word2byte_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int DEF_WORD_BYTES = 4;

   // Index of the final byte to emit; empty only trims the last word of a message.
   function automatic int last_index(int word_bytes, logic eop, int empty);
      return eop ? word_bytes - 1 - empty : word_bytes - 1;
   endfunction

endpackage

// File: rtl/avst_word2byte_if.sv
// avst_word2byte_if: word-side input stream and byte-side output stream of the serializer.
interface avst_word2byte_if #(
   parameter int WORD_BYTES = avst_word2byte_pkg::DEF_WORD_BYTES
);

   localparam int EMPTY_W = $clog2(WORD_BYTES);

   logic [8*WORD_BYTES-1:0] data_in;
   logic [EMPTY_W-1:0]      empty_in;
   logic                    end_in;
   logic                    valid_in;
   logic                    ready_in;
   logic [7:0]              data_out;
   logic                    end_out;
   logic                    valid_out;
   logic                    ready_out;

   modport master (
      output data_in, empty_in, end_in, valid_in, ready_out,
      input  ready_in, data_out, end_out, valid_out
   );

   modport slave (
      input  data_in, empty_in, end_in, valid_in, ready_out,
      output ready_in, data_out, end_out, valid_out
   );

endinterface

// File: rtl/avst_word2byte_hold.sv
// avst_word2byte_hold: one-word holding register with registered ready, used by the
// AVST_WORD2BYTE_SKID_EN build to refill the shifter without a bubble.
module avst_word2byte_hold
   import avst_word2byte_pkg::*;
#(
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic                            pop,
   input  logic [8*WORD_BYTES-1:0]         push_data,
   input  logic [$clog2(WORD_BYTES)-1:0]   push_empty,
   input  logic                            push_end,
   output logic                            full,
   output logic                            ready,
   output logic [8*WORD_BYTES-1:0]         hold_data,
   output logic [$clog2(WORD_BYTES)-1:0]   hold_empty,
   output logic                            hold_end
);

   logic full_nxt;

   // A push on the same edge as a pop leaves the register full.
   assign full_nxt = push | (full & !pop);

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         full       <= 1'b0;
         ready      <= 1'b0;
         hold_data  <= '0;
         hold_empty <= '0;
         hold_end   <= 1'b0;
      end else begin
         full  <= full_nxt;
         ready <= !full_nxt;
         if (push) begin
            hold_data  <= push_data;
            hold_empty <= push_empty;
            hold_end   <= push_end;
         end
      end

endmodule

// File: rtl/avst_word2byte.sv
// avst_word2byte: serializes a word stream into an LSB-first byte stream for avst_keccak.
// Define AVST_WORD2BYTE_SKID_EN to add a holding register for bubble-free 1 byte/cycle.
module avst_word2byte
   import avst_word2byte_pkg::*;
#(
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input logic            clk,
   input logic            reset,
   avst_word2byte_if.slave bus
);

   localparam int EMPTY_W = $clog2(WORD_BYTES);
   localparam int WW      = 8*WORD_BYTES;

   state_t             state;
   logic [WW-1:0]      shift_reg, src_data;
   logic [EMPTY_W-1:0] byte_idx, last_idx, idx_inc, src_empty, src_last;
   logic               is_end, src_end, push, xfer, last_xfer, take, load;

   assign push      = bus.valid_in & bus.ready_in;
   assign xfer      = bus.valid_out & bus.ready_out;
   assign last_xfer = xfer & (byte_idx == last_idx);
   // The shifter can take a new word when idle or as its last byte leaves.
   assign take      = (state == IDLE) | last_xfer;
   assign idx_inc   = byte_idx + 1'b1;
   assign src_last  = EMPTY_W'(last_index(WORD_BYTES, src_end, int'(src_empty)));
   assign bus.data_out = shift_reg[7:0];

`ifdef AVST_WORD2BYTE_SKID_EN
   logic               hold_full, hold_ready, hold_end;
   logic [WW-1:0]      hold_data;
   logic [EMPTY_W-1:0] hold_empty;

   // Held word goes first; an incoming word bypasses the holder only when it is empty.
   avst_word2byte_hold #(.WORD_BYTES(WORD_BYTES)) u_hold (
      .clk        (clk),
      .reset      (reset),
      .push       (push & !(take & !hold_full)),
      .pop        (take & hold_full),
      .push_data  (bus.data_in),
      .push_empty (bus.empty_in),
      .push_end   (bus.end_in),
      .full       (hold_full),
      .ready      (hold_ready),
      .hold_data  (hold_data),
      .hold_empty (hold_empty),
      .hold_end   (hold_end)
   );

   assign load      = take & (hold_full | push);
   assign src_data  = hold_full ? hold_data  : bus.data_in;
   assign src_empty = hold_full ? hold_empty : bus.empty_in;
   assign src_end   = hold_full ? hold_end   : bus.end_in;
   assign bus.ready_in = hold_ready;
`else
   logic ready_r;

   assign load      = take & push;
   assign src_data  = bus.data_in;
   assign src_empty = bus.empty_in;
   assign src_end   = bus.end_in;
   assign bus.ready_in = ready_r;
`endif

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= IDLE;
         shift_reg     <= '0;
         byte_idx      <= '0;
         last_idx      <= '0;
         is_end        <= 1'b0;
         bus.valid_out <= 1'b0;
         bus.end_out   <= 1'b0;
`ifndef AVST_WORD2BYTE_SKID_EN
         ready_r       <= 1'b0;
`endif
      end else begin
         if (load) begin
            state         <= SHIFT;
            shift_reg     <= src_data;
            byte_idx      <= '0;
            last_idx      <= src_last;
            is_end        <= src_end;
            bus.valid_out <= 1'b1;
            bus.end_out   <= src_end & (src_last == '0);
         end else if (last_xfer) begin
            state         <= IDLE;
            bus.valid_out <= 1'b0;
            bus.end_out   <= 1'b0;
         end else if (xfer) begin
            shift_reg     <= shift_reg >> 8;
            byte_idx      <= idx_inc;
            bus.end_out   <= is_end & (idx_inc == last_idx);
         end
`ifndef AVST_WORD2BYTE_SKID_EN
         ready_r <= take & !load;
`endif
      end

endmodule

// File: tb/tb_avst_word2byte.sv
// tb_avst_word2byte: scoreboard bench; expected bytes queued at word accept, popped at byte transfer.
module tb_avst_word2byte;

`ifdef AVST_WORD2BYTE_SKID_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 2;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   int         checks = 0, errors = 0, cyc = 0, acc = 0, b = 0;
   logic [8:0] sb[$];
   int         xc[$];
   logic       prev_stall = 1'b0;
   logic [8:0] prev_out = '0;
   logic [3:0] pat = 4'b1001;

   avst_word2byte_if #(.WORD_BYTES(4)) bus ();

   avst_word2byte #(.WORD_BYTES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (!reset) prev_stall <= 1'b0;
      else begin
         if (prev_stall) begin
            check("stall_valid", 32'(bus.valid_out), 32'd1);
            check("stall_hold", {bus.end_out, bus.data_out}, prev_out);
         end
         if (bus.valid_out && bus.ready_out) begin
            xc.push_back(cyc);
            if (sb.size() == 0) check("sb_nonempty", sb.size(), 1);
            else check("byte", {bus.end_out, bus.data_out}, sb.pop_front());
         end
         prev_stall <= bus.valid_out & !bus.ready_out;
         prev_out   <= {bus.end_out, bus.data_out};
      end

   task automatic expect_word(logic [31:0] d, int empty, logic eop);
      int n;
      n = eop ? 4 - empty : 4;
      for (int i = 0; i < n; i++) sb.push_back({eop && i == n - 1, d[8*i +: 8]});
   endtask

   task automatic send(logic [31:0] d, int empty, logic eop);
      bus.data_in  = d;
      bus.empty_in = 2'(empty);
      bus.end_in   = eop;
      bus.valid_in = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.ready_in) begin
            expect_word(d, empty, eop);
            acc = cyc + 1;
            @(posedge clk);
            #1 bus.valid_in = 1'b0;
            return;
         end
      end
      check("accept_timeout", 32'(bus.ready_in), 32'd1);
      bus.valid_in = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.valid_out) return;
      end
      check("drain_timeout", sb.size() + 32'(bus.valid_out), 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.data_in   = '0;
      bus.empty_in  = '0;
      bus.end_in    = 1'b0;
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_end", 32'(bus.end_out), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      check("rst_ready", 32'(bus.ready_in), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      check("ready_after_rst", 32'(bus.ready_in), 32'd1);
      // single word, full width
      b = xc.size();
      send(32'h44332211, 0, 1'b1);
      drain();
      check("t1_count", xc.size() - b, 4);
      check("t1_latency", xc[b], acc);
      check("t1_span", xc[b+3] - xc[b], 3);
      check("t1_ready", 32'(bus.ready_in), 32'd1);
      // two-word message, trimmed tail
      next_cycle();
      b = xc.size();
      send(32'h04030201, 0, 1'b0);
      send(32'h00000605, 2, 1'b1);
      drain();
      check("t2_count", xc.size() - b, 6);
      check("t2_gap", xc[b+4] - xc[b+3], GAP);
      // backpressure
      next_cycle();
      b = xc.size();
      fork
         send(32'hDDCCBBAA, 0, 1'b1);
         begin
            for (int i = 0; i < 16; i++) begin
               bus.ready_out = pat[i%4];
               next_cycle();
            end
            bus.ready_out = 1'b1;
         end
      join
      drain();
      check("t3_count", xc.size() - b, 4);
      // empty boundary, with and without end
      next_cycle();
      b = xc.size();
      send(32'h12345678, 3, 1'b1);
      drain();
      check("t4_one_byte", xc.size() - b, 1);
      next_cycle();
      b = xc.size();
      send(32'h9ABCDEF0, 3, 1'b0);
      send(32'h11111111, 0, 1'b1);
      drain();
      check("t4_ignore_empty", xc.size() - b, 8);
      // reset mid-word
      next_cycle();
      b = xc.size();
      send(32'h55667788, 0, 1'b1);
      for (int t = 0; t < 50 && xc.size() < b + 2; t++) next_cycle();
      reset = 1'b0;
      #1;
      check("t5_async_valid", 32'(bus.valid_out), 32'd0);
      check("t5_async_end", 32'(bus.end_out), 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t5_rst_ready", 32'(bus.ready_in), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      b = xc.size();
      send(32'h0A0B0C0D, 0, 1'b1);
      drain();
      check("t5_count", xc.size() - b, 4);
`ifdef AVST_WORD2BYTE_SKID_EN
      // back-to-back words stream without bubbles
      next_cycle();
      b = xc.size();
      for (int i = 0; i < 8; i++) send(32'h01010101 * (i + 1), 0, i == 7);
      drain();
      check("t6_count", xc.size() - b, 32);
      check("t6_span", xc[b+31] - xc[b], 31);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/avst_word2byte.md
Name: avst_word2byte

Overview:
- Upstream feeder for avst_keccak: converts a word-wide Avalon-ST-style message stream (host/DMA side) into the byte stream (data/end/valid/ready) that avst_keccak consumes.
- Serializes each accepted word into WORD_BYTES bytes, least-significant byte first (Keccak lane byte order).
- Trims unused bytes of the final word using empty_in and propagates end-of-message onto the last emitted byte.

Parameters:
- WORD_BYTES, 4, bytes per input word; power of 2, 2..8.
- EMPTY_W, $clog2(WORD_BYTES), width of empty_in; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clk.
- data_in  in  8*WORD_BYTES  message word; byte 0 = data_in[7:0].
- empty_in  in  EMPTY_W  number of unused high bytes in the word; sampled only when end_in=1.
- end_in  in  1  word is the last of the message.
- valid_in  in  1  word present.
- ready_in  out  1  block accepts word this cycle.
- data_out  out  8  byte to avst_keccak data_in.
- end_out  out  1  last byte of message; to avst_keccak end_in.
- valid_out  out  1  byte present; to avst_keccak valid_in.
- ready_out  in  1  downstream accepts byte; from avst_keccak ready_in.

Behaviour:
- Handshakes:
  - Word transfer on a rising edge with valid_in & ready_in.
  - Byte transfer on a rising edge with valid_out & ready_out.
- Reset values: valid_out=0, end_out=0, data_out=0, ready_in=0 while reset=0; ready_in=1 in the first cycle after release.
- FSM, states IDLE and SHIFT:
  - IDLE: ready_in=1, valid_out=0. Word accepted -> load shift register, byte_idx=0, capture is_end=end_in, last_idx = end_in ? WORD_BYTES-1-empty_in : WORD_BYTES-1 -> SHIFT.
  - SHIFT: valid_out=1, data_out = shift_reg[7:0], end_out = is_end & (byte_idx==last_idx).
  - On byte transfer, if byte_idx != last_idx: shift right by 8 and increment byte_idx.
  - On byte transfer, if byte_idx == last_idx: -> IDLE (or reload per the optional feature).
- Stall: while valid_out=1 and ready_out=0, data_out, end_out and valid_out hold stable; no output change without a handshake.
- Latency: first byte valid in the cycle after the word-accept edge. Outputs are registered; no combinational path from inputs to outputs.
- Throughput (base build): WORD_BYTES bytes, then one idle cycle per word; ready_in=0 throughout SHIFT.
- empty_in:
  - Ignored (don't care) when end_in=0.
  - empty_in=WORD_BYTES-1 emits exactly one byte.
  - A message always ends with >=1 byte; zero-length messages are not supported.
- end_out pulses for exactly one byte transfer per message; the next message may start in the next word.
- Reset mid-word: current and held bytes are discarded and valid_out drops asynchronously. No partial message resumes; avst_keccak is reset by the same signal.

Optional Feature:
- Macro: AVST_WORD2BYTE_SKID_EN.
- Enabled:
  - Adds a one-word holding register (data, empty, end, full flag); ready_in = !hold_full, including during SHIFT.
  - A word accepted during SHIFT is stored in the holding register.
  - On the last-byte transfer with hold_full=1, the shift register reloads from the holding register on the same edge and stays in SHIFT. This gives zero bubbles: continuous 1 byte/cycle when ready_out=1.
  - A word accepted on the same edge the holding register empties into SHIFT is legal; the holding register stays full.
- Disabled: no holding register; behaviour is exactly the base FSM above, with one bubble cycle per word.

Decomposition:
- Package avst_word2byte_pkg:
  - State enum (IDLE, SHIFT).
  - Default WORD_BYTES.
  - Function computing last_idx from end/empty.
- Sub-module avst_word2byte_hold (holding register with valid/ready), instantiated only under AVST_WORD2BYTE_SKID_EN.

Test Plan:
1. Single word 0x44332211, end_in=1, empty_in=0, ready_out=1 -> bytes 11,22,33,44 on consecutive cycles; end_out only with 44; then ready_in=1.
2. Two words 0x04030201 / 0x0000_0605 (end, empty=2), ready_out=1 -> bytes 01..06; end_out on 06.
   - Base build: one idle cycle between 04 and 05.
   - SKID build: none.
3. Backpressure: word 0xDDCCBBAA, ready_out toggling 1,0,0,1,... -> every byte held stable while stalled; sequence AA,BB,CC,DD with no loss or duplication.
4. Boundary empty: end_in=1, empty_in=3 -> exactly one byte emitted (data_in[7:0]) with end_out=1. Also check empty_in=3 with end_in=0 -> 4 bytes emitted, empty ignored.
5. Reset mid-word: assert reset=0 after the 2nd byte -> valid_out falls immediately; after release, a new word 0x0A0B0C0D (end) emits 0D,0C,0B,0A only.
6. SKID build only: 8 back-to-back words with ready_out=1 -> 32 consecutive byte transfers with valid_out never low; ready_in deasserts only while the holding register is full.
